// File: rtl/rs422_bert_if.sv
// rs422_bert_if: OPB-mapped RS422 bit-error-rate tester with one UART transmitter and N_RX checking receivers.
module rs422_bert_if #(
  parameter int N_TX            = 5,
  parameter int N_RX            = 9,
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int DRAIN_CYCLES    = 20000
) (
  input  logic            OPB_CLK,
  input  logic            OPB_RST,
  input  logic [31:0]     OPB_DI,
  output logic [31:0]     OPB_DO,
  input  logic [31:0]     OPB_ADDR,
  input  logic            RS422_RE,
  input  logic            RS422_WE,
  input  logic [N_RX-1:0] RS422_RXD,
  output logic [N_TX-1:0] RS422_TXD
);
  localparam logic [31:0] BIT        = 32'(CLOCK_FREQUENCY / BAUD_RATE);
  localparam logic [31:0] HALF       = 32'(CLOCK_FREQUENCY / BAUD_RATE / 2 - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [7:0] nxt(input logic [1:0] m, input logic [7:0] x);
    return m == 2'd1 ? x + 8'd1 : m == 2'd2 ? {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]} : x;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return x + {31'b0, x != '1};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  seed_q, gen_q;
  logic [31:0] tx_bytes_q, tx_count_q, drain_q, do_q, rd_d;
  logic [5:0]  ctrl_q;
  logic        done_q, stopped_q;
  logic [15:0] pass_q, pass_d;
  logic        tx_busy_q;
  logic [31:0] tx_cnt_q;
  logic [3:0]  tx_idx_q;
  logic [9:0]  tx_sh_q;
  logic [N_RX-1:0] s1_q, s2_q, rbusy_q, rstb_q, seeded_q;
  logic [31:0] rcnt_q [N_RX];
  logic [3:0]  ridx_q [N_RX];
  logic [7:0]  rsh_q  [N_RX];
  logic [7:0]  prev_q [N_RX];
  logic [31:0] recv_q [N_RX];
  logic [31:0] err_q  [N_RX];
  logic [1:0]  mode;
  logic        start, stop, clr, fixed, run_end, ack, enter_run, enter_done, active;
  logic        unused_addr;

  assign unused_addr = ^OPB_ADDR[31:8];
  assign start       = ctrl_q[0];
  assign stop        = ctrl_q[1];
  assign clr         = ctrl_q[2];
  assign mode        = ctrl_q[5:4];
  assign fixed       = mode != 2'd1 && mode != 2'd2;
  assign active      = state_q == RUN || state_q == DRAIN;
  assign run_end     = stop || (tx_bytes_q != 0 && tx_count_q == tx_bytes_q);
  assign ack         = state_q == RUN && !run_end && !clr && !tx_busy_q;
  assign enter_run   = state_d == RUN && state_q != RUN;
  assign enter_done  = state_d == DONE && state_q == DRAIN;
  assign OPB_DO      = do_q;
  assign RS422_TXD   = {N_TX{tx_busy_q ? tx_sh_q[0] : 1'b1}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? RUN : state_q;
      RUN:        state_d = run_end ? DRAIN : state_q;
      DRAIN:      state_d = drain_q == DRAIN_LAST ? DONE : state_q;
      default:    state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    pass_d = '0;
    for (int n = 0; n < N_RX; n++) pass_d[n] = recv_q[n] == tx_count_q && err_q[n] == 0;
  end

  always_comb begin
    rd_d = '0;
    case (OPB_ADDR[7:0])
      8'h00:   rd_d = {24'b0, seed_q};
      8'h01:   rd_d = tx_bytes_q;
      8'h02:   rd_d = {26'b0, ctrl_q};
      8'h03:   rd_d = {pass_q, 13'b0, stopped_q, done_q, active};
      8'h04:   rd_d = tx_count_q;
      default: rd_d = '0;
    endcase
    for (int n = 0; n < N_RX; n++) begin
      if (OPB_ADDR[7:0] == 8'(16 + n)) rd_d = recv_q[n];
      if (OPB_ADDR[7:0] == 8'(32 + n)) rd_d = err_q[n];
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      tx_bytes_q <= '0;
      ctrl_q     <= '0;
      tx_count_q <= '0;
      gen_q      <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      stopped_q  <= 1'b0;
      pass_q     <= '0;
      do_q       <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q[2:0] <= '0;
      if (RS422_WE && OPB_ADDR[7:0] == 8'h00) seed_q <= OPB_DI[7:0];
      if (RS422_WE && OPB_ADDR[7:0] == 8'h01) tx_bytes_q <= OPB_DI;
      if (RS422_WE && OPB_ADDR[7:0] == 8'h02) ctrl_q <= OPB_DI[5:0];
      if (RS422_RE) do_q <= rd_d;
      drain_q <= state_q == DRAIN && !clr ? drain_q + 32'd1 : '0;
      if (clr) begin
        tx_count_q <= '0;
        done_q     <= 1'b0;
        stopped_q  <= 1'b0;
        pass_q     <= '0;
      end else if (enter_run) begin
        tx_count_q <= '0;
        done_q     <= 1'b0;
        pass_q     <= '0;
        gen_q      <= mode == 2'd2 && seed_q == 8'h00 ? 8'h01 : seed_q;
      end else begin
        if (ack) begin
          tx_count_q <= sat_inc(tx_count_q);
          gen_q      <= nxt(mode, gen_q);
        end
        if (state_q == RUN && stop) stopped_q <= 1'b1;
        if (enter_done) begin
          done_q <= 1'b1;
          pass_q <= pass_d;
        end
      end
    end
  end

  // Frame is start bit, 8 data bits LSB first, stop bit; shifted out of tx_sh_q[0].
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '0;
    end else if (ack) begin
      tx_busy_q <= 1'b1;
      tx_sh_q   <= {1'b1, gen_q, 1'b0};
      tx_cnt_q  <= BIT - 32'd1;
      tx_idx_q  <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != 0) tx_cnt_q <= tx_cnt_q - 32'd1;
      else if (tx_idx_q == 4'd9) tx_busy_q <= 1'b0;
      else begin
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_idx_q <= tx_idx_q + 4'd1;
        tx_cnt_q <= BIT - 32'd1;
      end
    end
  end

  // Receivers sample at bit centres; the checker keeps the last byte so a bad byte resyncs the stream.
  always_ff @(posedge OPB_CLK) begin
    for (int n = 0; n < N_RX; n++) begin
      if (OPB_RST) begin
        s1_q[n]     <= 1'b0;
        s2_q[n]     <= 1'b0;
        rbusy_q[n]  <= 1'b0;
        rstb_q[n]   <= 1'b0;
        rcnt_q[n]   <= '0;
        ridx_q[n]   <= '0;
        rsh_q[n]    <= '0;
        seeded_q[n] <= 1'b0;
        prev_q[n]   <= '0;
        recv_q[n]   <= '0;
        err_q[n]    <= '0;
      end else begin
        s1_q[n]   <= RS422_RXD[n];
        s2_q[n]   <= s1_q[n];
        rstb_q[n] <= 1'b0;
        if (!rbusy_q[n]) begin
          if (!s2_q[n]) begin
            rbusy_q[n] <= 1'b1;
            rcnt_q[n]  <= HALF;
            ridx_q[n]  <= '0;
          end
        end else if (rcnt_q[n] != 0) rcnt_q[n] <= rcnt_q[n] - 32'd1;
        else begin
          rcnt_q[n] <= BIT - 32'd1;
          ridx_q[n] <= ridx_q[n] + 4'd1;
          if (ridx_q[n] == 4'd0 && s2_q[n]) rbusy_q[n] <= 1'b0;
          if (ridx_q[n] != 4'd0 && ridx_q[n] != 4'd9) rsh_q[n] <= {s2_q[n], rsh_q[n][7:1]};
          if (ridx_q[n] == 4'd9) begin
            rbusy_q[n] <= 1'b0;
            rstb_q[n]  <= s2_q[n];
          end
        end
        if (clr || enter_run) begin
          seeded_q[n] <= 1'b0;
          prev_q[n]   <= '0;
          recv_q[n]   <= '0;
          err_q[n]    <= '0;
        end else if (rstb_q[n] && active) begin
          recv_q[n]   <= sat_inc(recv_q[n]);
          seeded_q[n] <= 1'b1;
          prev_q[n]   <= rsh_q[n];
          if (!(tx_bytes_q != 0 && recv_q[n] >= tx_bytes_q) &&
              (fixed ? rsh_q[n] != seed_q : seeded_q[n] && rsh_q[n] != nxt(mode, prev_q[n])))
            err_q[n] <= sat_inc(err_q[n]);
        end
      end
    end
  end
endmodule

// File: tb/tb_rs422_bert_if.sv
// tb_rs422_bert_if: loops TX back to every RX, scoreboards decoded TX bytes and checks the register results.
`timescale 1ns/1ps
module tb_rs422_bert_if;
  localparam int N_TX = 5;
  localparam int N_RX = 9;
  localparam int BIT  = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            re = 1'b0;
  logic            we = 1'b0;
  logic [31:0]     di = '0;
  logic [31:0]     addr = '0;
  logic [31:0]     dout;
  logic [N_RX-1:0] rxd;
  logic [N_TX-1:0] txd;
  logic            cor_on = 1'b0;
  logic            cor_bit = 1'b0;
  logic            cor_en = 1'b0;
  logic            mon_en = 1'b1;
  logic [7:0]      cor_byte = 8'h55;
  int              cor_fr = 0;
  int              fr = 0;
  logic [7:0]      sbq[$];
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  assign rxd = cor_on ? (({N_RX{txd[0]}} & ~(N_RX'(1) << 2)) | (N_RX'(cor_bit) << 2)) : {N_RX{txd[0]}};

  rs422_bert_if #(
    .N_TX(N_TX), .N_RX(N_RX), .BAUD_RATE(100000), .CLOCK_FREQUENCY(1000000), .DRAIN_CYCLES(300)
  ) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_DI(di), .OPB_DO(dout), .OPB_ADDR(addr),
    .RS422_RE(re), .RS422_WE(we), .RS422_RXD(rxd), .RS422_TXD(txd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_f(input int m, input logic [7:0] x);
    logic [7:0] y;
    case (m)
      1:       y = x + 8'd1;
      2:       y = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
      default: y = x;
    endcase
    return y;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = {24'b0, a};
    di = v;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = {24'b0, a};
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    v = dout;
  endtask

  // Decodes TXD[0] frames, optionally corrupting channel 2's copy of one frame.
  initial forever begin
    logic [7:0] b;
    @(negedge txd[0]);
    repeat (BIT / 2) @(negedge clk);
    if (txd[0] == 1'b0) begin
      fr++;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        cor_on = cor_en && fr == cor_fr;
        cor_bit = cor_byte[i];
        repeat (BIT / 2) @(negedge clk);
        b[i] = txd[0];
        repeat (BIT / 2) @(negedge clk);
      end
      cor_on = 1'b0;
      repeat (BIT / 2) @(negedge clk);
      if (mon_en) begin
        chk("tx_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) chk("tx_byte", {24'b0, b}, {24'b0, sbq.pop_front()});
      end
    end
  end

  task automatic run_bert(input int mode, input logic [7:0] seed, input logic [31:0] n,
                          input int npush, input int bad_ch, input logic [31:0] exp_st);
    logic [7:0]  x;
    logic [31:0] d;
    x = (mode == 2 && seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < npush; i++) begin
      sbq.push_back(x);
      x = model_f(mode, x);
    end
    fr = 0;
    wr(8'h00, {24'b0, seed});
    wr(8'h01, n);
    wr(8'h02, 32'((mode << 4) | 1));
    if (n == 0) begin
      for (int k = 0; k < 2000; k++) begin
        rd(8'h04, d);
        if (d >= 32'(npush)) break;
      end
      chk("stop_poll", d, 32'(npush));
      wr(8'h02, 32'((mode << 4) | 2));
    end
    for (int k = 0; k < 4000; k++) begin
      rd(8'h03, d);
      if (d[1]) break;
    end
    chk("done_seen", {31'b0, d[1]}, 32'd1);
    rd(8'h04, d);
    chk("tx_count", d, 32'(npush));
    for (int c = 0; c < N_RX; c++) begin
      rd(8'(16 + c), d);
      chk($sformatf("recv%0d", c), d, 32'(npush));
      rd(8'(32 + c), d);
      chk($sformatf("err%0d", c), d, c == bad_ch ? 32'd2 : 32'd0);
    end
    rd(8'h03, d);
    chk("status", d, exp_st);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    @(negedge clk);
    chk("rst_do", dout, 32'd0);
    chk("rst_txd", {27'b0, txd}, 32'h1F);
    rst = 1'b0;
    rd(8'h03, d);
    chk("rst_status", d, 32'd0);
    rd(8'h00, d);
    chk("rst_seed", d, 32'd0);

    run_bert(0, 8'hA5, 32'd4, 4, -1, 32'h01FF0002);
    cor_en = 1'b1;
    cor_fr = 2;
    run_bert(1, 8'hFE, 32'd3, 3, 2, 32'h01FB0002);
    cor_en = 1'b0;
    run_bert(2, 8'h00, 32'd4, 4, -1, 32'h01FF0002);
    run_bert(1, 8'h10, 32'd0, 10, -1, 32'h01FF0006);

    wr(8'h02, 32'h5);
    repeat (200) @(negedge clk);
    rd(8'h03, d);
    chk("clr_status", d, 32'd0);
    rd(8'h04, d);
    chk("clr_tx_count", d, 32'd0);
    rd(8'h10, d);
    chk("clr_recv0", d, 32'd0);
    rd(8'h02, d);
    chk("clr_ctrl", d, 32'd0);
    chk("clr_no_tx", 32'(sbq.size()), 32'd0);

    mon_en = 1'b0;
    wr(8'h00, 32'h33);
    wr(8'h01, 32'd5);
    wr(8'h02, 32'h1);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!txd[0]) break;
    end
    chk("midframe", {31'b0, txd[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", {27'b0, txd}, 32'h1F);
    chk("mid_rst_do", dout, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd(8'(a), d);
      chk($sformatf("mid_rst_reg%0d", a), d, 32'd0);
    end
    rd(8'h10, d);
    chk("mid_rst_recv0", d, 32'd0);
    repeat (20) @(negedge clk);
    chk("post_rst_txd", {27'b0, txd}, 32'h1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
